// File: rtl/ram_port_ctrl_if.sv
// ----------------------------------------------------------------------------
// ram_port_ctrl_if
//   Request/response bundle between a client and ram_port_ctrl.
//
//   Request channel  : req_valid/req_ready handshake carrying req_we,
//                      req_addr and req_wdata (write data ignored on reads).
//   Response channel : rsp_valid/rsp_ready handshake carrying rsp_data
//                      (read data only; writes produce no response).
//
//   modport master : the client (drives requests, consumes responses).
//   modport slave  : the controller.
// ----------------------------------------------------------------------------
interface ram_port_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/ram_port_ctrl.sv
// ----------------------------------------------------------------------------
// ram_port_ctrl
//   Front end that owns the single port of an attached sync_ram. It accepts
//   read/write requests over a valid/ready channel, sequences the RAM strobes
//   and returns read data over a valid/ready response channel. A built-in fill
//   engine writes base + n*step to every word n on command.
//
// Ports
//   clk, rst_n        : clock (posedge) and asynchronous active-low reset
//   init_start        : one-cycle pulse, starts a fill (honoured only in IDLE)
//   init_value/step   : fill base and increment, sampled when the fill starts
//   init_done         : sticky, set when a fill completes
//   busy              : high whenever the controller is not idle
//   bus               : request/response channel (slave side)
//   ram_din/addr      : registered RAM data-in and address
//   ram_writeEn/read  : registered RAM strobes
//   ram_dout          : RAM read data (valid after the edge that sampled read)
//
// Timing
//   Write : accepted at edge k, writeEn high k..k+1, next accept at k+2.
//   Read  : accepted at edge k, read high k..k+1, data captured at k+2 with
//           rsp_valid rising at that edge, i.e. three edges after the edge
//           that opened the handshake cycle.
//   Fill  : DEPTH writes on DEPTH consecutive edges, then init_done rises on
//           the edge that commits the last word.
// ----------------------------------------------------------------------------
module ram_port_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  init_start,
  input  logic [DATA_WIDTH-1:0] init_value,
  input  logic [DATA_WIDTH-1:0] init_step,
  output logic                  init_done,
  output logic                  busy,

  ram_port_ctrl_if.slave        bus,

  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_writeEn,
  output logic                  ram_read,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  // The fill counter is one bit wider than the address so that "all DEPTH
  // words issued" is a distinct value and the address never wraps to 0.
  localparam logic [ADDR_WIDTH:0] FILL_END = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RD_CAP,
    S_RSP,
    S_FILL
  } state_e;

  state_e                state_q, state_d;

  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] step_q, step_d;

  logic [DATA_WIDTH-1:0] din_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  we_d;
  logic                  rd_d;

  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  done_d;

  // A fill request in the same cycle wins over a client request, so the
  // client must not see ready in that cycle.
  assign bus.req_ready = (state_q == S_IDLE) && !init_start;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = (state_q != S_IDLE);

  // --------------------------------------------------------------------------
  // Next-state and next-register logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    step_d      = step_q;
    din_d       = ram_din;
    addr_d      = ram_addr;
    we_d        = 1'b0;          // strobes are single-cycle unless re-asserted
    rd_d        = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    done_d      = init_done;

    unique case (state_q)
      S_IDLE: begin
        if (init_start) begin
          done_d  = 1'b0;
          cnt_d   = '0;
          acc_d   = init_value;
          step_d  = init_step;
          state_d = S_FILL;
        end else if (bus.req_valid) begin
          addr_d = bus.req_addr;
          if (bus.req_we) begin
            din_d   = bus.req_wdata;
            we_d    = 1'b1;
            state_d = S_WR;
          end else begin
            rd_d    = 1'b1;
            state_d = S_RD;
          end
        end
      end

      // The write commits on the edge leaving this state.
      S_WR: state_d = S_IDLE;

      // The RAM samples read on the edge leaving this state.
      S_RD: state_d = S_RD_CAP;

      // ram_dout now holds the addressed word.
      S_RD_CAP: begin
        rsp_data_d  = ram_dout;
        rsp_valid_d = 1'b1;
        state_d     = S_RSP;
      end

      S_RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      S_FILL: begin
        if (cnt_q == FILL_END) begin
          // The last word commits on this edge; finish without rewriting 0.
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          addr_d = cnt_q[ADDR_WIDTH-1:0];
          din_d  = acc_q;
          we_d   = 1'b1;
          cnt_d  = cnt_q + CNT_ONE;
          acc_d  = acc_q + step_q;     // wraps modulo 2^DATA_WIDTH
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  // NOTE: every register here has a defined reset value because the RAM sees
  // ram_* directly; a stray strobe after reset would corrupt its contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      step_q      <= '0;
      ram_din     <= '0;
      ram_addr    <= '0;
      ram_writeEn <= 1'b0;
      ram_read    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      init_done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // pre-edge values regardless of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      ram_din     <= din_d;
      ram_addr    <= addr_d;
      ram_writeEn <= we_d;
      ram_read    <= rd_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      init_done   <= done_d;
    end
  end

endmodule

// File: tb/tb_ram_port_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ram_port_ctrl
//   Drives ram_port_ctrl with a behavioural sync_ram attached and compares
//   against a word-array model of what the RAM should hold. Inputs change and
//   outputs are sampled on the falling clock edge. Edge numbers: cyc counts
//   rising edges; at a falling edge it is the index of the last rising edge.
// ----------------------------------------------------------------------------
module tb_ram_port_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init_start;
  logic [DW-1:0] init_value;
  logic [DW-1:0] init_step;
  logic          init_done;
  logic          busy;
  logic [DW-1:0] ram_din;
  logic [AW-1:0] ram_addr;
  logic          ram_writeEn;
  logic          ram_read;
  logic [DW-1:0] ram_dout;

  ram_port_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_start  (init_start),
    .init_value  (init_value),
    .init_step   (init_step),
    .init_done   (init_done),
    .busy        (busy),
    .bus         (bus),
    .ram_din     (ram_din),
    .ram_addr    (ram_addr),
    .ram_writeEn (ram_writeEn),
    .ram_read    (ram_read),
    .ram_dout    (ram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural sync_ram attached to the controller.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_writeEn) mem[ram_addr] <= ram_din;
    if (ram_read)    ram_dout      <= mem[ram_addr];
  end

  // Reference model of intended RAM contents.
  logic [DW-1:0] exp_mem [DEPTH];

  // Bus monitors.
  int cyc = 0;
  int we_total = 0;
  int xfer_total = 0;
  int we_log_addr [$];
  int we_log_edge [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_writeEn) begin
      we_total <= we_total + 1;
      we_log_addr.push_back(int'(ram_addr));
      we_log_edge.push_back(cyc + 1);
    end
    if (bus.rsp_valid && bus.rsp_ready) xfer_total <= xfer_total + 1;
  end

  int n_pass = 0;
  int n_total = 0;

  // --------------------------------------------------------------------------
  // Stimulus helpers (called at a falling edge, return at a falling edge)
  // --------------------------------------------------------------------------
  task automatic issue(input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input string tag,
                       output int acc_edge);
    int waited = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (!bus.req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_total++;
    if (!bus.req_ready)
      $display("FAIL %s_accept_timeout addr=%0d req_ready=%b required 1", tag, a, bus.req_ready);
    else n_pass++;
    @(negedge clk);
    acc_edge      = cyc;
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;    // later changes must not matter
    if (we) exp_mem[a] = d;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input string tag);
    int acc;
    int waited = 0;
    issue(1'b0, a, '0, tag, acc);
    while (!bus.rsp_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_total++;
    if (!bus.rsp_valid)
      $display("FAIL %s_rsp_timeout addr=%0d rsp_valid=0 required 1", tag, a);
    else if (cyc != acc + 2)
      $display("FAIL %s_latency addr=%0d rsp_valid at edge %0d required %0d", tag, a, cyc, acc + 2);
    else n_pass++;
    n_total++;
    if (bus.rsp_data !== exp_mem[a])
      $display("FAIL %s_data addr=%0d got=%h required=%h", tag, a, bus.rsp_data, exp_mem[a]);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic do_fill(input logic [DW-1:0] v, input logic [DW-1:0] s, input string tag);
    int waited = 0;
    int errs = 0;
    we_log_addr.delete();
    we_log_edge.delete();
    init_value = v;
    init_step  = s;
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    init_value = $urandom;       // the sampled copy must be used
    init_step  = $urandom;
    while (!init_done && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    n_total++;
    if (!init_done) $display("FAIL %s_done_timeout init_done=0 required 1", tag);
    else n_pass++;
    n_total++;
    if (we_log_addr.size() != DEPTH)
      $display("FAIL %s_write_count got=%0d required=%0d", tag, we_log_addr.size(), DEPTH);
    else n_pass++;
    for (int i = 0; i < DEPTH && i < we_log_addr.size(); i++)
      if (we_log_addr[i] != i || we_log_edge[i] != we_log_edge[0] + i) errs++;
    n_total++;
    if (errs != 0) $display("FAIL %s_write_sequence bad_entries=%0d required 0", tag, errs);
    else n_pass++;
    if (we_log_edge.size() == DEPTH) begin
      n_total++;
      if (cyc != we_log_edge[DEPTH-1])
        $display("FAIL %s_done_timing rise edge=%0d required=%0d", tag, cyc, we_log_edge[DEPTH-1]);
      else n_pass++;
    end
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = v + s * DW'(i);
    @(negedge clk);
    errs = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) errs++;
    n_total++;
    if (errs != 0 || busy !== 1'b0)
      $display("FAIL %s_contents bad_words=%0d busy=%b required 0/0", tag, errs, busy);
    else n_pass++;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    init_start = 1'b0; init_value = '0; init_step = '0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({ram_writeEn, ram_read, bus.rsp_valid, init_done, busy} !== 5'b0 ||
        ram_addr !== '0 || ram_din !== '0 || bus.rsp_data !== '0 || bus.req_ready !== 1'b1)
      $display("FAIL reset_state we=%b rd=%b rv=%b done=%b busy=%b addr=%h din=%h rdata=%h rdy=%b required all 0 with rdy=1",
               ram_writeEn, ram_read, bus.rsp_valid, init_done, busy, ram_addr, ram_din, bus.rsp_data, bus.req_ready);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int acc [DEPTH];
    int errs = 0;
    for (int i = 0; i < DEPTH; i++) issue(1'b1, AW'(i), DW'(2 * i + 1), "wr_seq", acc[i]);
    for (int i = 1; i < DEPTH; i++) if (acc[i] != acc[i-1] + 2) errs++;
    n_total++;
    if (errs != 0) $display("FAIL write_spacing bad_gaps=%0d required 0", errs);
    else n_pass++;
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) do_read(AW'(i), "rd_seq");
  endtask

  task automatic test_fill();
    do_fill(32'd1, 32'd2, "fill_a");
    do_read(4'd7, "fill_a_rd7");
    n_total++;
    if (exp_mem[7] !== 32'd15) $display("FAIL fill_a_model got=%h required=%h", exp_mem[7], 32'd15);
    else n_pass++;
    do_fill(32'hFFFF_FFFF, 32'd1, "fill_b");
    do_read(4'd1, "fill_b_rd1");
    n_total++;
    if (bus.rsp_data !== 32'd0) $display("FAIL fill_b_wrap got=%h required=%h", bus.rsp_data, 32'd0);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int acc;
    int waited = 0;
    int errs = 0;
    int base;
    logic [DW-1:0] held;
    bus.rsp_ready = 1'b0;
    issue(1'b0, 4'd3, '0, "bp", acc);
    while (!bus.rsp_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    held = bus.rsp_data;
    n_total++;
    if (!bus.rsp_valid || held !== exp_mem[3])
      $display("FAIL bp_first rsp_valid=%b data=%h required 1/%h", bus.rsp_valid, held, exp_mem[3]);
    else n_pass++;
    base = xfer_total;
    // A competing write is offered while the response is pending.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 4'd3; bus.req_wdata = ~exp_mem[3];
    repeat (5) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_data !== held || bus.req_ready || !busy) errs++;
    end
    n_total++;
    if (errs != 0) $display("FAIL bp_hold unstable_cycles=%0d required 0", errs);
    else n_pass++;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.rsp_valid !== 1'b0 || xfer_total - base != 1)
      $display("FAIL bp_release rsp_valid=%b transfers=%0d required 0/1", bus.rsp_valid, xfer_total - base);
    else n_pass++;
    do_read(4'd3, "bp_after");   // the offered write must not have landed
  endtask

  task automatic test_simultaneous();
    int waited = 0;
    int acc;
    int base;
    init_value = 32'h100; init_step = 32'd3; init_start = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 4'd9; bus.req_wdata = 32'hBAD0_0009;
    #1;
    n_total++;
    if (bus.req_ready !== 1'b0) $display("FAIL sim_ready got=%b required 0", bus.req_ready);
    else n_pass++;
    @(negedge clk);
    init_start = 1'b0; bus.req_valid = 1'b0;
    n_total++;
    if (busy !== 1'b1 || init_done !== 1'b0)
      $display("FAIL sim_fill_start busy=%b done=%b required 1/0", busy, init_done);
    else n_pass++;
    while (!init_done && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h100 + 32'd3 * DW'(i);
    @(negedge clk);
    do_read(4'd9, "sim_rd9");

    base = we_total;
    issue(1'b1, 4'd4, 32'h0A5A_5A5A, "wr_ign", acc);
    init_value = 32'h7; init_step = 32'h7; init_start = 1'b1;   // during WR
    @(negedge clk);
    init_start = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (init_done !== 1'b1 || busy !== 1'b0 || we_total - base != 1)
      $display("FAIL init_in_wr done=%b busy=%b writes=%0d required 1/0/1", init_done, busy, we_total - base);
    else n_pass++;
    do_read(4'd4, "wr_ign_rd");
  endtask

  task automatic test_back_to_back();
    int acc;
    issue(1'b1, 4'd5, 32'hDEAD_BEEF, "b2b", acc);
    do_read(4'd5, "b2b_rd");
  endtask

  task automatic test_random();
    int acc;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(1, 0) == 1) issue(1'b1, AW'($urandom), DW'($urandom), "rnd_wr", acc);
      else do_read(AW'($urandom), "rnd_rd");
    end
  endtask

  task automatic test_reset_mid_op();
    int acc;
    int waited = 0;
    int base;
    // During RSP with init_done set from the preceding fill.
    bus.rsp_ready = 1'b0;
    issue(1'b0, 4'd2, '0, "rst_rsp", acc);
    while (!bus.rsp_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0 || init_done !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_in_rsp rv=%b rdata=%h done=%b busy=%b required all 0",
               bus.rsp_valid, bus.rsp_data, init_done, busy);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_rsp_discard rv=%b busy=%b required 0/0", bus.rsp_valid, busy);
    else n_pass++;

    // During FILL.
    init_value = 32'h55; init_step = 32'h1; init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    base = we_total;
    n_total++;
    if ({ram_writeEn, ram_read, bus.rsp_valid, init_done, busy} !== 5'b0 ||
        ram_addr !== '0 || ram_din !== '0)
      $display("FAIL rst_in_fill we=%b rd=%b rv=%b done=%b busy=%b addr=%h din=%h required all 0",
               ram_writeEn, ram_read, bus.rsp_valid, init_done, busy, ram_addr, ram_din);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_total++;
    if (we_total != base || busy !== 1'b0 || init_done !== 1'b0)
      $display("FAIL rst_fill_quiet writes=%0d busy=%b done=%b required 0/0/0", we_total - base, busy, init_done);
    else n_pass++;

    // Contents are partly rewritten; re-establish and spot-check.
    do_fill(32'h1000, 32'h10, "fill_c");
    do_read(4'd15, "fill_c_rd15");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_fill();
    test_backpressure();
    test_simultaneous();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
